// File: rtl/gray_stream_decoder_if.sv
// Valid/ready stream bundle for gray_stream_decoder: Gray samples in, binary plus
// step class and jump count out. The decoder side uses the slave modport.
interface gray_stream_decoder_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] binary;
    logic [1:0]       out_dir;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, gray, out_ready,
        input  in_ready, out_valid, binary, out_dir, err_count
    );

    modport slave (
        input  in_valid, gray, out_ready,
        output in_ready, out_valid, binary, out_dir, err_count
    );
endinterface

// File: rtl/gray_stream_decoder.sv
// Two-stage Gray-to-binary stream decoder with optional step classifier and
// saturating jump counter, enabled by defining GRAY_DEC_STEP_CHECK_EN.
module gray_stream_decoder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    gray_stream_decoder_if.slave bus
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_gray_q, s1_gray_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_bin_q, s2_bin_d;
    logic [WIDTH-1:0] dec_bin;
    logic             s2_load;
    logic             s1_move;
    logic             in_ready_c;
    logic             accept;

    always_comb begin
        dec_bin = '0;
        dec_bin[WIDTH-1] = s1_gray_q[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            dec_bin[i] = dec_bin[i+1] ^ s1_gray_q[i];
        end
    end

    // Stage 2 frees up in the same cycle it emits, so in_ready depends on out_ready.
    always_comb begin
        s2_load    = !s2_valid_q || bus.out_ready;
        s1_move    = s2_load && s1_valid_q;
        in_ready_c = !rst && (!s1_valid_q || s2_load);
        accept     = bus.in_valid && in_ready_c;

        s1_valid_d = s1_valid_q;
        s1_gray_d  = s1_gray_q;
        s2_valid_d = s2_valid_q;
        s2_bin_d   = s2_bin_q;

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = 1'b0;
        end
        if (s1_move) begin
            s2_bin_d = dec_bin;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_gray_d  = bus.gray;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_gray_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_bin_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_gray_q  <= s1_gray_d;
            s2_valid_q <= s2_valid_d;
            s2_bin_q   <= s2_bin_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = s2_valid_q;
    assign bus.binary    = s2_bin_q;

`ifdef GRAY_DEC_STEP_CHECK_EN
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             has_ref_q, has_ref_d;
    logic [1:0]       dir_q, dir_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [WIDTH-1:0] ref_inc;
    logic [WIDTH-1:0] ref_dec;
    logic             emit;

    // Classification is taken as the sample enters stage 2, so it travels with the data.
    always_comb begin
        ref_inc   = ref_q + WIDTH'(1);
        ref_dec   = ref_q - WIDTH'(1);
        emit      = s2_valid_q && bus.out_ready;
        ref_d     = ref_q;
        has_ref_d = has_ref_q;
        dir_d     = dir_q;
        err_d     = err_q;

        if (s1_move) begin
            ref_d     = dec_bin;
            has_ref_d = 1'b1;
            if (!has_ref_q || dec_bin == ref_q) begin
                dir_d = 2'b00;
            end else if (dec_bin == ref_inc) begin
                dir_d = 2'b01;
            end else if (dec_bin == ref_dec) begin
                dir_d = 2'b10;
            end else begin
                dir_d = 2'b11;
            end
        end

        if (emit && dir_q == 2'b11 && err_q != {CNT_W{1'b1}}) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q     <= '0;
            has_ref_q <= 1'b0;
            dir_q     <= 2'b00;
            err_q     <= '0;
        end else begin
            ref_q     <= ref_d;
            has_ref_q <= has_ref_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
        end
    end

    assign bus.out_dir   = dir_q;
    assign bus.err_count = err_q;
`else
    assign bus.out_dir   = 2'b00;
    assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder: streams, wrap, jump, stall and reset cases
// with hand-written expected binaries and step classes checked at every emit.
module tb_gray_stream_decoder;

    typedef struct {
        logic [7:0] b;
        logic [1:0] d;
        int         c;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   cyc;
    int   err_model;
    bit   lat_chk;
    bit   thru_chk;
    exp_t exp_q[$];

    gray_stream_decoder_if #(.WIDTH(8), .CNT_W(8)) bus ();

    gray_stream_decoder #(.WIDTH(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [1:0] edir(input logic [1:0] d);
`ifdef GRAY_DEC_STEP_CHECK_EN
        return d;
`else
        return d & 2'b00;
`endif
    endfunction

    // One cycle: drive at the negedge, observe after settling, then wait for the next negedge.
    task automatic step(input bit iv, input logic [7:0] b, input logic [1:0] d,
                        input bit ordy, output bit acc);
        exp_t e;
        bus.in_valid  = iv;
        bus.gray      = b ^ (b >> 1);
        bus.out_ready = ordy;
        #1;
        acc = iv && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_emit", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("binary", bus.binary, e.b);
                chk("out_dir", bus.out_dir, edir(e.d));
                chk("err_count", bus.err_count, err_model);
                if (lat_chk) chk("latency", cyc - e.c, 2);
                if (edir(e.d) == 2'b11 && err_model != 255) err_model++;
            end
        end
        if (acc) exp_q.push_back('{b: b, d: d, c: cyc});
        @(negedge clk);
        cyc++;
    endtask

    task automatic feed(input logic [7:0] b, input logic [1:0] d, input bit ordy);
        bit acc;
        int tries;
        tries = 0;
        do begin
            step(1'b1, b, d, ordy, acc);
            tries++;
        end while (!acc && tries < 20);
        chk("feed_accept", acc, 1);
        if (thru_chk) chk("throughput", tries, 1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            step(1'b0, 8'h00, 2'b00, 1'b1, acc);
            n++;
        end
        chk("drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        cyc++;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_binary", bus.binary, 0);
        chk("rst_out_dir", bus.out_dir, 0);
        chk("rst_err_count", bus.err_count, 0);
        exp_q.delete();
        err_model = 0;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_err_count", bus.err_count, 0);
    endtask

    initial begin
        bit acc;
        int n_acc;
        logic [7:0] nb;
        n_chk = 0;
        n_err = 0;
        cyc = 0;
        err_model = 0;
        lat_chk = 1'b0;
        thru_chk = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.gray = '0;
        bus.out_ready = 1'b0;

        // Full ascending sweep: back-to-back accepts, latency 2, hold then all ups.
        do_reset();
        lat_chk = 1'b1;
        for (int k = 0; k < 256; k++) begin
            thru_chk = (k != 0);
            feed(8'(k), (k == 0) ? 2'b00 : 2'b01, 1'b1);
        end
        thru_chk = 1'b0;
        drain();
        lat_chk = 1'b0;
        chk("sweep_err_count", bus.err_count, 0);

        // Wrap-around in both directions.
        do_reset();
        feed(8'hFE, 2'b00, 1'b1);
        feed(8'hFF, 2'b01, 1'b1);
        feed(8'h00, 2'b01, 1'b1);
        feed(8'hFF, 2'b10, 1'b1);
        drain();

        // Repeat then a non-adjacent value.
        do_reset();
        feed(8'h10, 2'b00, 1'b1);
        feed(8'h10, 2'b00, 1'b1);
        feed(8'h40, 2'b11, 1'b1);
        drain();
        step(1'b0, 8'h00, 2'b00, 1'b1, acc);
        chk("jump_err_count", bus.err_count, err_model);

        // Fill both stages, then reset mid-operation.
        feed(8'h41, 2'b00, 1'b0);
        feed(8'h42, 2'b00, 1'b0);
        do_reset();
        feed(8'h55, 2'b00, 1'b1);
        drain();

        // Backpressure: five cycles of out_ready low with in_valid high.
        do_reset();
        nb = 8'h20;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, nb, (nb == 8'h20) ? 2'b00 : 2'b01, 1'b0, acc);
            if (acc) begin
                nb = nb + 8'd1;
                n_acc++;
            end
            if (i >= 3) chk("stall_hold_binary", bus.binary, 8'h20);
        end
        chk("stall_accepts", n_acc, 2);
        #1;
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        chk("stall_out_dir", bus.out_dir, 0);
        step(1'b1, 8'h22, 2'b01, 1'b1, acc);
        chk("full_emit_accept", acc, 1);
        feed(8'h23, 2'b01, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
